// File: rtl/mouse_pos_tracker.sv
// Mouse cursor position tracker.
// Turns PS/2-style mouse packets (status, DX, DY) into a clamped screen position.
// It also tracks the button levels and click pulses, and counts packets it had to drop.
// Ports:
//   CLK, RESET                   - single clock; synchronous active-high reset
//   MOUSE_STATUS/DX/DY           - packet bytes; STATUS = {YV,XV,YS,XS,1,0,R,L}
//   INTERRUPT                    - packet-ready level; a rising edge means a new packet
//   LOAD_EN, LOAD_X, LOAD_Y      - force the position (the value is clamped to the screen)
//   MOUSE_POS_X/Y                - current position
//   POS_VALID                    - one-cycle pulse after each packet-driven update
//   BTN_L/R, CLICK_L/R           - button levels and 0->1 click pulses
//   DROP_CNT                     - saturating count of dropped packets
module mouse_pos_tracker #(
  parameter int unsigned POS_W    = 10,
  parameter int unsigned X_MAX    = 639,
  parameter int unsigned Y_MAX    = 479,
  parameter int unsigned X_INIT   = 320,
  parameter int unsigned Y_INIT   = 240,
  parameter int unsigned SHIFT    = 0,
  parameter bit          Y_INVERT = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       MOUSE_STATUS,
  input  logic [7:0]       MOUSE_DX,
  input  logic [7:0]       MOUSE_DY,
  input  logic             INTERRUPT,
  input  logic             LOAD_EN,
  input  logic [POS_W-1:0] LOAD_X,
  input  logic [POS_W-1:0] LOAD_Y,
  output logic [POS_W-1:0] MOUSE_POS_X,
  output logic [POS_W-1:0] MOUSE_POS_Y,
  output logic             POS_VALID,
  output logic             BTN_L,
  output logic             BTN_R,
  output logic             CLICK_L,
  output logic             CLICK_R,
  output logic [7:0]       DROP_CNT
);

  // Two guard bits hold the sum of a position and a +/-256 delta without wrapping.
  localparam int unsigned SW = POS_W + 2;
  localparam logic signed [SW-1:0] X_MAX_S = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_MAX_S = SW'(Y_MAX);

  typedef enum logic [1:0] {IDLE, CALC, CLAMP} state_t;

  state_t state, state_next;

  logic int_d;
  logic int_edge;
  logic capture_c, calc_c, clamp_c, drop_c;

  // Captured packet fields.
  logic       xs_q, ys_q, xv_q, yv_q;
  logic [7:0] dx_q, dy_q;

  logic signed [SW-1:0] sum_x, sum_y;

  // Reserved status bits (constant 1,0 in the packet) carry no information.
  logic unused_status;
  assign unused_status = ^MOUSE_STATUS[3:2];

  assign int_edge = INTERRUPT & ~int_d;

  // Signed 9-bit delta, scaled by SHIFT, forced to zero on overflow.
  function automatic logic signed [SW-1:0] delta(input logic sgn, input logic [7:0] mag,
                                                 input logic ovf);
    logic signed [8:0] d9;
    logic signed [8:0] sh;
    d9 = signed'({sgn, mag});
    sh = d9 >>> SHIFT;
    if (ovf) return '0;
    return SW'(sh);
  endfunction

  // Saturate a signed sum into [0, maxv].
  function automatic logic [POS_W-1:0] clamp(input logic signed [SW-1:0] s,
                                             input logic signed [SW-1:0] maxv);
    if (s[SW-1])    return '0;
    if (s > maxv)   return POS_W'(maxv);
    return POS_W'(s);
  endfunction

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; LOAD_EN overrides any in-flight update.
  always_comb begin
    state_next = state;
    if (LOAD_EN) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (int_edge) state_next = CALC;
        CALC:    state_next = CLAMP;
        CLAMP:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    capture_c = 1'b0;
    calc_c    = 1'b0;
    clamp_c   = 1'b0;
    drop_c    = 1'b0;
    if (!LOAD_EN) begin
      capture_c = (state == IDLE) && int_edge;
      calc_c    = (state == CALC);
      clamp_c   = (state == CLAMP);
    end
    drop_c = int_edge && (LOAD_EN || (state != IDLE));
  end

  // Datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      int_d       <= 1'b0;
      xs_q        <= 1'b0;
      ys_q        <= 1'b0;
      xv_q        <= 1'b0;
      yv_q        <= 1'b0;
      dx_q        <= '0;
      dy_q        <= '0;
      sum_x       <= '0;
      sum_y       <= '0;
      MOUSE_POS_X <= POS_W'(X_INIT);
      MOUSE_POS_Y <= POS_W'(Y_INIT);
      POS_VALID   <= 1'b0;
      BTN_L       <= 1'b0;
      BTN_R       <= 1'b0;
      CLICK_L     <= 1'b0;
      CLICK_R     <= 1'b0;
      DROP_CNT    <= '0;
    end else begin
      int_d     <= INTERRUPT;
      POS_VALID <= 1'b0;
      CLICK_L   <= 1'b0;
      CLICK_R   <= 1'b0;

      if (drop_c && (DROP_CNT != 8'hFF)) DROP_CNT <= DROP_CNT + 8'd1;

      if (LOAD_EN) begin
        MOUSE_POS_X <= clamp(signed'({2'b00, LOAD_X}), X_MAX_S);
        MOUSE_POS_Y <= clamp(signed'({2'b00, LOAD_Y}), Y_MAX_S);
      end

      if (capture_c) begin
        yv_q    <= MOUSE_STATUS[7];
        xv_q    <= MOUSE_STATUS[6];
        ys_q    <= MOUSE_STATUS[5];
        xs_q    <= MOUSE_STATUS[4];
        dx_q    <= MOUSE_DX;
        dy_q    <= MOUSE_DY;
        BTN_R   <= MOUSE_STATUS[1];
        BTN_L   <= MOUSE_STATUS[0];
        CLICK_R <= MOUSE_STATUS[1] & ~BTN_R;
        CLICK_L <= MOUSE_STATUS[0] & ~BTN_L;
      end

      if (calc_c) begin
        sum_x <= signed'({2'b00, MOUSE_POS_X}) + delta(xs_q, dx_q, xv_q);
        if (Y_INVERT) sum_y <= signed'({2'b00, MOUSE_POS_Y}) - delta(ys_q, dy_q, yv_q);
        else          sum_y <= signed'({2'b00, MOUSE_POS_Y}) + delta(ys_q, dy_q, yv_q);
      end

      if (clamp_c) begin
        MOUSE_POS_X <= clamp(sum_x, X_MAX_S);
        MOUSE_POS_Y <= clamp(sum_y, Y_MAX_S);
        POS_VALID   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Self-checking bench for mouse_pos_tracker (default parameters).
// A transaction-level model tracks the expected position, buttons and drop count.
module tb_mouse_pos_tracker;

  localparam int XMAX = 639;
  localparam int YMAX = 479;
  localparam int SHIFT_P = 0;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
  logic       INTERRUPT, LOAD_EN;
  logic [9:0] LOAD_X, LOAD_Y;
  logic [9:0] MOUSE_POS_X, MOUSE_POS_Y;
  logic       POS_VALID, BTN_L, BTN_R, CLICK_L, CLICK_R;
  logic [7:0] DROP_CNT;

  int checks = 0;
  int errors = 0;

  // Model state.
  int m_x, m_y, m_drop, m_busy, m_dx, m_dy;
  bit m_valid, m_btn_l, m_btn_r, m_click_l, m_click_r, m_int_prev;

  mouse_pos_tracker dut (
    .CLK(CLK), .RESET(RESET),
    .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY),
    .INTERRUPT(INTERRUPT), .LOAD_EN(LOAD_EN), .LOAD_X(LOAD_X), .LOAD_Y(LOAD_Y),
    .MOUSE_POS_X(MOUSE_POS_X), .MOUSE_POS_Y(MOUSE_POS_Y), .POS_VALID(POS_VALID),
    .BTN_L(BTN_L), .BTN_R(BTN_R), .CLICK_L(CLICK_L), .CLICK_R(CLICK_R),
    .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic int clampi(int v, int m);
    return (v < 0) ? 0 : ((v > m) ? m : v);
  endfunction

  // Signed magnitude scaled by 2^-SHIFT with floor rounding; zero on overflow.
  function automatic int delta_m(bit s, int mag, bit ovf);
    int d;
    int den;
    if (ovf) return 0;
    d = s ? mag - 256 : mag;
    den = 1 << SHIFT_P;
    if (d >= 0) return d / den;
    return -((-d + den - 1) / den);
  endfunction

  // Advance the model by one clock with the given inputs.
  task automatic model_step(bit rst, bit intr, bit ld, int lx, int ly, int st, int dx, int dy);
    bit e;
    if (rst) begin
      m_x = 320; m_y = 240; m_drop = 0; m_busy = 0;
      m_valid = 0; m_btn_l = 0; m_btn_r = 0; m_click_l = 0; m_click_r = 0;
      m_int_prev = 0;
      return;
    end
    e = intr && !m_int_prev;
    m_valid = 0; m_click_l = 0; m_click_r = 0;
    if (ld) begin
      m_x = clampi(lx, XMAX); m_y = clampi(ly, YMAX); m_busy = 0;
      if (e && m_drop < 255) m_drop++;
    end else if (m_busy > 0) begin
      if (e && m_drop < 255) m_drop++;
      m_busy--;
      if (m_busy == 0) begin
        m_x = clampi(m_x + m_dx, XMAX);
        m_y = clampi(m_y - m_dy, YMAX);
        m_valid = 1;
      end
    end else if (e) begin
      m_dx = delta_m(st[4], dx & 8'hFF, st[6]);
      m_dy = delta_m(st[5], dy & 8'hFF, st[7]);
      m_click_l = st[0] && !m_btn_l;
      m_click_r = st[1] && !m_btn_r;
      m_btn_l = st[0]; m_btn_r = st[1];
      m_busy = 2;
    end
    m_int_prev = intr;
  endtask

  // Drive one cycle of inputs, update the model, sample 1 time unit after the edge.
  task automatic cyc(bit rst, bit intr, bit ld, int lx, int ly, int st, int dx, int dy);
    RESET = rst; INTERRUPT = intr; LOAD_EN = ld;
    LOAD_X = 10'(lx); LOAD_Y = 10'(ly);
    MOUSE_STATUS = 8'(st); MOUSE_DX = 8'(dx); MOUSE_DY = 8'(dy);
    model_step(rst, intr, ld, lx, ly, st, dx, dy);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();          cyc(0, 0, 0, 0, 0, 0, 0, 0);        endtask
  task automatic pkt(int st, int dx, int dy); cyc(0, 1, 0, 0, 0, st, dx, dy); endtask
  task automatic load(int lx, int ly); cyc(0, 0, 1, lx, ly, 0, 0, 0); endtask
  task automatic do_reset();      cyc(1, 0, 0, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0, 0, 0); endtask

  task automatic test_reset();
    do_reset();
    idle();
    checks++;
    if (MOUSE_POS_X !== 10'd320 || MOUSE_POS_Y !== 10'd240) begin
      errors++; $display("FAIL reset_pos got (%0d,%0d) exp (320,240)", MOUSE_POS_X, MOUSE_POS_Y);
    end
    checks++;
    if (POS_VALID !== 1'b0 || DROP_CNT !== 8'd0 || BTN_L !== 1'b0 || CLICK_L !== 1'b0) begin
      errors++; $display("FAIL reset_flags got valid=%0b drop=%0d btn_l=%0b click_l=%0b exp 0 0 0 0",
                         POS_VALID, DROP_CNT, BTN_L, CLICK_L);
    end
  endtask

  task automatic test_basic();
    pkt(8'h08, 8'h0A, 8'h05);
    idle();
    checks++;
    if (MOUSE_POS_X !== 10'd320 || POS_VALID !== 1'b0) begin
      errors++; $display("FAIL basic_early got x=%0d valid=%0b exp x=320 valid=0", MOUSE_POS_X, POS_VALID);
    end
    idle();
    checks++;
    if (MOUSE_POS_X !== 10'd330 || MOUSE_POS_Y !== 10'd235 || POS_VALID !== 1'b1) begin
      errors++; $display("FAIL basic_update got (%0d,%0d) valid=%0b exp (330,235) valid=1",
                         MOUSE_POS_X, MOUSE_POS_Y, POS_VALID);
    end
    idle();
    checks++;
    if (POS_VALID !== 1'b0) begin
      errors++; $display("FAIL basic_pulse_width got valid=%0b exp 0", POS_VALID);
    end
  endtask

  task automatic test_clamp();
    load(5, 240); idle();
    pkt(8'h18, 8'hF0, 0); idle(); idle();
    checks++;
    if (MOUSE_POS_X !== 10'd0) begin
      errors++; $display("FAIL clamp_low got x=%0d exp 0", MOUSE_POS_X);
    end
    load(635, 240); idle();
    pkt(8'h08, 8'h0A, 0); idle(); idle();
    checks++;
    if (MOUSE_POS_X !== 10'd639) begin
      errors++; $display("FAIL clamp_high got x=%0d exp 639", MOUSE_POS_X);
    end
    load(100, 470); idle();
    pkt(8'h28, 0, 8'hE0); idle(); idle();
    checks++;
    if (MOUSE_POS_Y !== 10'd479) begin
      errors++; $display("FAIL clamp_y_high got y=%0d exp 479", MOUSE_POS_Y);
    end
  endtask

  task automatic test_overflow();
    load(320, 240); idle();
    pkt(8'h48, 8'h20, 8'h10); idle(); idle();
    checks++;
    if (MOUSE_POS_X !== 10'd320 || MOUSE_POS_Y !== 10'd224) begin
      errors++; $display("FAIL overflow got (%0d,%0d) exp (320,224)", MOUSE_POS_X, MOUSE_POS_Y);
    end
  endtask

  task automatic test_zero_delta();
    load(50, 60); idle();
    pkt(8'h08, 0, 0); idle(); idle();
    checks++;
    if (POS_VALID !== 1'b1 || MOUSE_POS_X !== 10'd50 || MOUSE_POS_Y !== 10'd60) begin
      errors++; $display("FAIL zero_delta got (%0d,%0d) valid=%0b exp (50,60) valid=1",
                         MOUSE_POS_X, MOUSE_POS_Y, POS_VALID);
    end
  endtask

  task automatic test_drop();
    int pulses;
    do_reset();
    pulses = 0;
    pkt(8'h08, 8'h04, 0);
    cyc(0, 0, 0, 0, 0, 8'h08, 8'h40, 0);
    cyc(0, 1, 0, 0, 0, 8'h08, 8'h40, 0);
    pulses += POS_VALID;
    for (int i = 0; i < 6; i++) begin idle(); pulses += POS_VALID; end
    checks++;
    if (DROP_CNT !== 8'd1 || pulses != 1 || MOUSE_POS_X !== 10'd324) begin
      errors++; $display("FAIL drop_single got drop=%0d pulses=%0d x=%0d exp 1 1 324",
                         DROP_CNT, pulses, MOUSE_POS_X);
    end
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1, 1, 320, 240, 0, 0, 0);
      idle();
    end
    checks++;
    if (DROP_CNT !== 8'd255) begin
      errors++; $display("FAIL drop_saturate got %0d exp 255", DROP_CNT);
    end
  endtask

  task automatic test_load_abort();
    do_reset();
    pkt(8'h08, 8'h0A, 8'h05);
    idle();
    load(700, 10);
    checks++;
    if (MOUSE_POS_X !== 10'd639 || MOUSE_POS_Y !== 10'd10 || POS_VALID !== 1'b0) begin
      errors++; $display("FAIL load_clamp got (%0d,%0d) valid=%0b exp (639,10) valid=0",
                         MOUSE_POS_X, MOUSE_POS_Y, POS_VALID);
    end
    idle();
    checks++;
    if (POS_VALID !== 1'b0 || MOUSE_POS_X !== 10'd639) begin
      errors++; $display("FAIL load_no_update got x=%0d valid=%0b exp 639 0", MOUSE_POS_X, POS_VALID);
    end
    pkt(8'h18, 8'hFF, 0); idle(); idle();
    checks++;
    if (MOUSE_POS_X !== 10'd638 || POS_VALID !== 1'b1) begin
      errors++; $display("FAIL load_then_idle got x=%0d valid=%0b exp 638 1", MOUSE_POS_X, POS_VALID);
    end
  endtask

  task automatic test_click();
    do_reset();
    pkt(8'h09, 0, 0);
    checks++;
    if (BTN_L !== 1'b1 || CLICK_L !== 1'b1 || CLICK_R !== 1'b0) begin
      errors++; $display("FAIL click_first got btn_l=%0b click_l=%0b click_r=%0b exp 1 1 0",
                         BTN_L, CLICK_L, CLICK_R);
    end
    idle();
    checks++;
    if (CLICK_L !== 1'b0) begin
      errors++; $display("FAIL click_width got %0b exp 0", CLICK_L);
    end
    idle(); idle();
    pkt(8'h09, 0, 0);
    checks++;
    if (BTN_L !== 1'b1 || CLICK_L !== 1'b0) begin
      errors++; $display("FAIL click_repeat got btn_l=%0b click_l=%0b exp 1 0", BTN_L, CLICK_L);
    end
    idle(); idle(); idle();
    pkt(8'h0A, 0, 0);
    checks++;
    if (BTN_L !== 1'b0 || BTN_R !== 1'b1 || CLICK_R !== 1'b1) begin
      errors++; $display("FAIL click_right got btn_l=%0b btn_r=%0b click_r=%0b exp 0 1 1",
                         BTN_L, BTN_R, CLICK_R);
    end
  endtask

  task automatic test_reset_mid();
    load(100, 100); idle();
    pkt(8'h08, 8'h10, 8'h10);
    idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (POS_VALID !== 1'b0 || MOUSE_POS_X !== 10'd320 || MOUSE_POS_Y !== 10'd240) begin
      errors++; $display("FAIL reset_mid got (%0d,%0d) valid=%0b exp (320,240) valid=0",
                         MOUSE_POS_X, MOUSE_POS_Y, POS_VALID);
    end
    idle(); idle();
    checks++;
    if (POS_VALID !== 1'b0 || MOUSE_POS_X !== 10'd320) begin
      errors++; $display("FAIL reset_mid_after got x=%0d valid=%0b exp 320 0", MOUSE_POS_X, POS_VALID);
    end
  endtask

  task automatic test_random();
    bit intr, ld, rst;
    int st;
    do_reset();
    intr = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) intr = ~intr;
      ld  = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) == 0);
      st  = int'($urandom_range(0, 255)) | 8'h08;
      cyc(rst, intr, ld, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
          st, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      checks++;
      if (MOUSE_POS_X !== 10'(m_x) || MOUSE_POS_Y !== 10'(m_y)) begin
        errors++; $display("FAIL rand_pos cyc %0d got (%0d,%0d) exp (%0d,%0d)",
                           i, MOUSE_POS_X, MOUSE_POS_Y, m_x, m_y);
      end
      checks++;
      if (POS_VALID !== m_valid || DROP_CNT !== 8'(m_drop)) begin
        errors++; $display("FAIL rand_valid_drop cyc %0d got valid=%0b drop=%0d exp %0b %0d",
                           i, POS_VALID, DROP_CNT, m_valid, m_drop);
      end
      checks++;
      if (BTN_L !== m_btn_l || BTN_R !== m_btn_r || CLICK_L !== m_click_l || CLICK_R !== m_click_r) begin
        errors++; $display("FAIL rand_buttons cyc %0d got %0b%0b%0b%0b exp %0b%0b%0b%0b", i,
                           BTN_L, BTN_R, CLICK_L, CLICK_R, m_btn_l, m_btn_r, m_click_l, m_click_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_overflow();
    test_zero_delta();
    test_drop();
    test_load_abort();
    test_click();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
